// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder: a valid/ready input
// channel carrying the operands and a valid/ready output channel carrying the result.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic [1:0]       dbg_state;

    // Each channel transfers on a rising edge where valid && ready.
    // A producer may not withdraw valid before that edge, and the
    // payload stays stable while valid is high and ready is low.
    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, dbg_state
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, dbg_state
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, carrying between
// chunks, and presents the WIDTH-bit result with carry and signed overflow.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic            clk,
    input logic            rst_n,
    chunked_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             last_chunk;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic             msb_cin;

    assign last_chunk = (k_r == KW'(NCHUNK - 1));

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_r == KW'(i)) begin
                chunk_a = a_r[i*CHUNK +: CHUNK];
                chunk_b = b_r[i*CHUNK +: CHUNK];
            end
        end
        {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_r};
        // The carry into a full adder's top bit is recoverable from its inputs and sum bit.
        msb_cin = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_chunk)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            k_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1, so the operands are folded here once.
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub | bus.carry_in;
                        k_r     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (k_r == KW'(i)) sum_r[i*CHUNK +: CHUNK] <= chunk_s;
                    end
                    carry_r <= chunk_c;
                    if (last_chunk) begin
                        k_r    <= '0;
                        cout_r <= chunk_c;
                        ovf_r  <= msb_cin ^ chunk_c;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.carry_out = cout_r;
    assign bus.overflow  = ovf_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: a vector table on the CHUNK=4 instance,
// plus backpressure, mid-run reset and CHUNK=16 / CHUNK=1 sequences.
module tb_chunked_adder;
    logic clk;
    logic rst_n;

    logic [15:0] a_d, b_d;
    logic        cin_d, sub_d, out_ready_d;
    logic        iv[3];
    logic        ir[3];
    logic        ov[3];
    logic [15:0] sm[3];
    logic        co[3];
    logic        of[3];

    int n_cmp = 0;
    int n_bad = 0;

    chunked_adder_if #(.WIDTH(16)) if4 (), if16 (), if1 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    chunked_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if4.a  = a_d;  assign if16.a  = a_d;  assign if1.a  = a_d;
    assign if4.b  = b_d;  assign if16.b  = b_d;  assign if1.b  = b_d;
    assign if4.carry_in = cin_d; assign if16.carry_in = cin_d; assign if1.carry_in = cin_d;
    assign if4.sub = sub_d; assign if16.sub = sub_d; assign if1.sub = sub_d;
    assign if4.out_ready = out_ready_d; assign if16.out_ready = out_ready_d; assign if1.out_ready = out_ready_d;
    assign if4.in_valid = iv[0]; assign if16.in_valid = iv[1]; assign if1.in_valid = iv[2];

    assign ir[0] = if4.in_ready;  assign ir[1] = if16.in_ready;  assign ir[2] = if1.in_ready;
    assign ov[0] = if4.out_valid; assign ov[1] = if16.out_valid; assign ov[2] = if1.out_valid;
    assign sm[0] = if4.sum;       assign sm[1] = if16.sum;       assign sm[2] = if1.sum;
    assign co[0] = if4.carry_out; assign co[1] = if16.carry_out; assign co[2] = if1.carry_out;
    assign of[0] = if4.overflow;  assign of[1] = if16.overflow;  assign of[2] = if1.overflow;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic accept(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
        a_d = a; b_d = b; cin_d = cin; sub_d = sub;
        iv[sel] = 1'b1;
        tick();
        iv[sel] = 1'b0;
    endtask

    task automatic wait_valid(input int sel, input logic noisy, output int lat);
        lat = 0;
        while (lat < 40) begin
            if (noisy) begin
                iv[sel] = 1'b1;
                a_d = 16'($urandom_range(0, 65535));
                b_d = 16'($urandom_range(0, 65535));
                cin_d = 1'($urandom_range(0, 1));
                sub_d = 1'($urandom_range(0, 1));
                out_ready_d = 1'b1;
            end
            tick();
            lat++;
            if (ov[sel]) break;
        end
        iv[sel] = 1'b0;
        out_ready_d = 1'b0;
    endtask

    task automatic consume(input int sel, input string tag);
        logic [15:0] held;
        held = sm[sel];
        out_ready_d = 1'b1;
        tick();
        out_ready_d = 1'b0;
        check({tag, " out_valid drop"}, 32'(ov[sel]), 32'd0);
        check({tag, " in_ready back"}, 32'(ir[sel]), 32'd1);
        check({tag, " sum retained"}, 32'(sm[sel]), 32'(held));
    endtask

    task automatic run_op(input int sel, input int nch, input string tag,
                          input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic noisy, input logic [15:0] e_sum,
                          input logic e_cout, input logic e_ovf);
        int lat;
        check({tag, " in_ready idle"}, 32'(ir[sel]), 32'd1);
        accept(sel, a, b, cin, sub);
        wait_valid(sel, noisy, lat);
        check({tag, " latency"}, 32'(lat), 32'(nch));
        check({tag, " sum"}, 32'(sm[sel]), 32'(e_sum));
        check({tag, " carry_out"}, 32'(co[sel]), 32'(e_cout));
        check({tag, " overflow"}, 32'(of[sel]), 32'(e_ovf));
        consume(sel, tag);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{16'hABCD, 16'h5432, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        // reset with in_valid asserted: must be ignored
        a_d = 16'h1111; b_d = 16'h2222; cin_d = 1'b0; sub_d = 1'b0; out_ready_d = 1'b0;
        for (int s = 0; s < 3; s++) iv[s] = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset%0d in_ready", s), 32'(ir[s]), 32'd1);
            check($sformatf("reset%0d out_valid", s), 32'(ov[s]), 32'd0);
            check($sformatf("reset%0d sum", s), 32'(sm[s]), 32'd0);
            check($sformatf("reset%0d carry_out", s), 32'(co[s]), 32'd0);
            check($sformatf("reset%0d overflow", s), 32'(of[s]), 32'd0);
        end
        for (int s = 0; s < 3; s++) iv[s] = 1'b0;
        rst_n = 1'b1;
        tick();

        // vector table; odd entries keep in_valid/out_ready busy during RUN
        for (int i = 0; i < 12; i++) begin
            run_op(0, 4, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sub, 1'(i % 2), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // backpressure with new operands presented
        accept(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_valid(0, 1'b0, lat);
        check("bp latency", 32'(lat), 32'd4);
        for (int c = 0; c < 3; c++) begin
            iv[0] = 1'b1;
            a_d = 16'hFFFF; b_d = 16'hFFFF; cin_d = 1'b1; sub_d = 1'b0;
            out_ready_d = 1'b0;
            tick();
            check($sformatf("bp%0d out_valid", c), 32'(ov[0]), 32'd1);
            check($sformatf("bp%0d in_ready", c), 32'(ir[0]), 32'd0);
            check($sformatf("bp%0d sum", c), 32'(sm[0]), 32'h2345);
            check($sformatf("bp%0d carry_out", c), 32'(co[0]), 32'd0);
            check($sformatf("bp%0d overflow", c), 32'(of[0]), 32'd0);
        end
        iv[0] = 1'b0;
        consume(0, "bp");

        // reset on the second RUN edge discards the partial result
        accept(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst in_ready", 32'(ir[0]), 32'd1);
        check("midrst out_valid", 32'(ov[0]), 32'd0);
        check("midrst sum", 32'(sm[0]), 32'd0);
        run_op(0, 4, "after_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        // parameter sweep
        run_op(1, 1, "c16", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(1, 1, "c16_sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(2, 16, "c1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op(2, 16, "c1_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have a port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have a port in_valid, input, 1 bit: the operand set is valid.
REQ-006 The block SHALL have a port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have a port a, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-008 The block SHALL have a port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have a port carry_in, input, 1 bit: the carry into bit 0, used when sub=0.
REQ-010 The block SHALL have a port sub, input, 1 bit: 0 selects A+B+carry_in, 1 selects A-B.
REQ-011 The block SHALL have a port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have a port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have a port sum, output, WIDTH bits: the result, modulo 2^WIDTH.
REQ-014 The block SHALL have a port carry_out, output, 1 bit: the carry out of bit WIDTH-1 (for sub, 1 means no borrow).
REQ-015 The block SHALL have a port overflow, output, 1 bit: two's-complement signed overflow of the result.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur on a rising edge with IDLE && in_valid, which captures a, b, the effective B (~b when sub=1), and the effective carry (1 when sub=1, else carry_in) into internal registers, then enters RUN with chunk index k=0.
REQ-018 After acceptance, input ports SHALL be ignored until the block returns to IDLE.
REQ-019 In RUN, each cycle SHALL add chunk k of A and effective B plus the registered carry, write sum[k*CHUNK +: CHUNK], and register the chunk carry-out as the next carry.
REQ-020 When k == NCHUNK-1, RUN SHALL move to DONE on that edge.
REQ-021 On the last chunk, the block SHALL register overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, and carry_out = the final chunk carry.
REQ-022 Latency SHALL be exactly NCHUNK cycles: out_valid rises on the NCHUNK-th rising edge after the acceptance edge, so CHUNK == WIDTH gives a latency of 1.
REQ-023 In DONE, out_valid SHALL be 1, and sum, carry_out and overflow SHALL hold stable until out_valid && out_ready on a rising edge.
REQ-024 On that out_valid && out_ready edge, the block SHALL return to IDLE with out_valid deasserted; a new operand is accepted no earlier than the following edge, so throughput is at most one result per NCHUNK+2 cycles.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 in_valid held high while the block is not in IDLE SHALL not be accepted and SHALL not corrupt state.
REQ-027 sum, carry_out and overflow SHALL retain the last result while in IDLE and RUN; only sum chunks k are overwritten in RUN.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL enter IDLE with k=0, the internal carry cleared, in_ready=1, out_valid=0, sum=0, carry_out=0 and overflow=0.
REQ-029 Reset SHALL take priority over every other condition, including in RUN and DONE, and a partially computed result SHALL be discarded.
REQ-030 While rst_n=0, in_valid SHALL be ignored, and the first acceptance is possible on the first edge with rst_n=1.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 Scenario unsigned wrap: a=0xFFFF, b=0x0001, carry_in=0, sub=0 -> out_valid exactly 4 cycles after acceptance, sum=0x0000, carry_out=1, overflow=0.
REQ-032 Scenario signed overflow: a=0x7FFF, b=0x0001, carry_in=0, sub=0 -> sum=0x8000, carry_out=0, overflow=1.
REQ-033 Scenario subtract and carry_in ignored: a=0x0005, b=0x0007, sub=1, carry_in=1 -> sum=0xFFFE, carry_out=0, overflow=0.
REQ-034 Scenario backpressure: result ready, out_ready=0 for 3 cycles with in_valid=1 and new operands presented -> out_valid, sum, carry_out and overflow stable, and in_ready=0 throughout; then out_ready=1 -> out_valid=0 next edge and in_ready=1.
REQ-035 Scenario reset mid-RUN: accept a=0x1234, b=0x1111, drive rst_n=0 on the 2nd RUN edge -> next edge in_ready=1, out_valid=0, sum=0; the following operation a=0x0001, b=0x0002 gives sum=0x0003.
REQ-036 Scenario parameter sweep: CHUNK=16 with 0x8000+0x8000 -> latency 1, sum=0x0000, carry_out=1, overflow=1; CHUNK=1 with 0x00FF+0x0001 -> latency 16, sum=0x0100, carry_out=0, overflow=0.
